// File: rtl/codec_intf.sv
// I2S master for the CS4272 codec: derives MCLK/SCLK/LRCLK from a free-running
// frame counter, deserializes SDout into sample pairs and serializes core samples onto SDin.
module codec_intf #(
  parameter int CNT_W  = 10,
  parameter int SMPL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SMPL_W-1:0] lft_out,
  input  logic [SMPL_W-1:0] rht_out,
  input  logic              SDout,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              SDin,
  output logic              RSTn,
  output logic [SMPL_W-1:0] lft_in,
  output logic [SMPL_W-1:0] rht_in,
  output logic              valid
);

  localparam int SLOT_W = CNT_W - 5;
  localparam int HALF   = 2 ** (CNT_W - 1);
  // Captures sit in slot 23 of each half, well clear of the data slots and frame edges.
  localparam logic [CNT_W-1:0] LFT_CAP = CNT_W'(23 * 16 + 15);
  localparam logic [CNT_W-1:0] RHT_CAP = CNT_W'(23 * 16 + 15 + HALF);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rstn_q, rstn_d;
  logic              valid_q, valid_d;
  logic [SMPL_W-1:0] rx_shft_q, rx_shft_d;
  logic [SMPL_W-1:0] lft_hold_q, lft_hold_d;
  logic [SMPL_W-1:0] lft_in_q, lft_in_d;
  logic [SMPL_W-1:0] rht_in_q, rht_in_d;
  logic [SMPL_W-1:0] tx_lft_buf_q, tx_lft_buf_d;
  logic [SMPL_W-1:0] tx_rht_buf_q, tx_rht_buf_d;
  logic [SMPL_W-1:0] tx_shft_q, tx_shft_d;

  logic [SLOT_W-1:0] slot;
  logic              rx_sample;
  logic              sclk_fall;
  logic              tx_load;

  always_comb begin
    slot      = cnt_q[CNT_W-2:4];
    rx_sample = (cnt_q[3:0] == 4'b0111) && (slot != '0) && (slot <= SLOT_W'(SMPL_W));
    sclk_fall = (cnt_q[3:0] == 4'b1111);
    tx_load   = (cnt_q[CNT_W-2:0] == (CNT_W-1)'(15));

    cnt_d        = cnt_q + CNT_W'(1);
    rstn_d       = rstn_q | (cnt_q == '1);
    valid_d      = rstn_q && (cnt_q == RHT_CAP);
    rx_shft_d    = rx_shft_q;
    lft_hold_d   = lft_hold_q;
    lft_in_d     = lft_in_q;
    rht_in_d     = rht_in_q;
    tx_lft_buf_d = tx_lft_buf_q;
    tx_rht_buf_d = tx_rht_buf_q;
    tx_shft_d    = tx_shft_q;

    if (rx_sample) begin
      rx_shft_d = {rx_shft_q[SMPL_W-2:0], SDout};
    end
    if (cnt_q == LFT_CAP) begin
      lft_hold_d = rx_shft_q;
    end
    if (cnt_q == RHT_CAP) begin
      lft_in_d = lft_hold_q;
      rht_in_d = rx_shft_q;
    end

    // Both buffers latch together so a mid-frame core update never splits a pair.
    if (cnt_q == '1) begin
      tx_lft_buf_d = lft_out;
      tx_rht_buf_d = rht_out;
    end
    if (tx_load) begin
      tx_shft_d = cnt_q[CNT_W-1] ? tx_rht_buf_q : tx_lft_buf_q;
    end else if (sclk_fall) begin
      tx_shft_d = {tx_shft_q[SMPL_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      rstn_q       <= 1'b0;
      valid_q      <= 1'b0;
      rx_shft_q    <= '0;
      lft_hold_q   <= '0;
      lft_in_q     <= '0;
      rht_in_q     <= '0;
      tx_lft_buf_q <= '0;
      tx_rht_buf_q <= '0;
      tx_shft_q    <= '0;
    end else begin
      cnt_q        <= cnt_d;
      rstn_q       <= rstn_d;
      valid_q      <= valid_d;
      rx_shft_q    <= rx_shft_d;
      lft_hold_q   <= lft_hold_d;
      lft_in_q     <= lft_in_d;
      rht_in_q     <= rht_in_d;
      tx_lft_buf_q <= tx_lft_buf_d;
      tx_rht_buf_q <= tx_rht_buf_d;
      tx_shft_q    <= tx_shft_d;
    end
  end

  assign MCLK   = cnt_q[1];
  assign SCLK   = cnt_q[3];
  assign LRCLK  = cnt_q[CNT_W-1];
  assign SDin   = tx_shft_q[SMPL_W-1];
  assign RSTn   = rstn_q;
  assign lft_in = lft_in_q;
  assign rht_in = rht_in_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_codec_intf.sv
// Directed bench for codec_intf: a simple codec model drives SDout, the bench
// decodes SDin and checks clock periods, reset sequencing and sample transfer.
module tb_codec_intf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lft_out;
  logic [15:0] rht_out;
  logic        SDout;
  logic        MCLK, SCLK, LRCLK, SDin, RSTn, valid;
  logic [15:0] lft_in, rht_in;

  codec_intf dut (
    .clk     (clk),
    .rst     (rst),
    .lft_out (lft_out),
    .rht_out (rht_out),
    .SDout   (SDout),
    .MCLK    (MCLK),
    .SCLK    (SCLK),
    .LRCLK   (LRCLK),
    .SDin    (SDin),
    .RSTn    (RSTn),
    .lft_in  (lft_in),
    .rht_in  (rht_in),
    .valid   (valid)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bench timebase: frame position as the codec sees it.
  logic [9:0] m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= '0;
    else     m_cnt <= m_cnt + 10'd1;
  end

  // Codec model: slot 1 carries the MSB; slot 0 and the 24-bit LSB slots carry 1s.
  logic [15:0] cod_lft, cod_rht;
  always_comb begin
    logic [15:0] word;
    int s;
    word  = m_cnt[9] ? cod_rht : cod_lft;
    s     = int'(m_cnt[8:4]);
    SDout = 1'b1;
    if (s >= 1 && s <= 16) SDout = word[16 - s];
  end

  int cyc;
  int mclk_bad, sclk_bad, lrclk_bad, mclk_rises, sclk_rises, lrclk_rises;
  int last_mclk, last_sclk, last_lrclk, last_valid;
  int valid_cnt, valid_wide, valid_gap_bad, tail_err;
  logic prev_mclk, prev_sclk, prev_lrclk, prev_valid;
  logic [15:0] dec_sh;
  logic [15:0] dec_l[$], dec_r[$], v_lft[$], v_rht[$];
  bit          swap_pending;
  logic [15:0] new_l, new_r;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearMonitor();
    mclk_bad = 0; sclk_bad = 0; lrclk_bad = 0;
    mclk_rises = 0; sclk_rises = 0; lrclk_rises = 0;
    last_mclk = -1; last_sclk = -1; last_lrclk = -1; last_valid = -1;
    valid_cnt = 0; valid_wide = 0; valid_gap_bad = 0; tail_err = 0;
    prev_mclk = MCLK; prev_sclk = SCLK; prev_lrclk = LRCLK; prev_valid = valid;
    dec_sh = '0;
    dec_l.delete(); dec_r.delete(); v_lft.delete(); v_rht.delete();
  endtask

  task automatic monitorOutputs();
    int s;
    if (MCLK && !prev_mclk) begin
      if (last_mclk >= 0 && cyc - last_mclk != 4) mclk_bad++;
      last_mclk = cyc; mclk_rises++;
    end
    if (SCLK && !prev_sclk) begin
      if (last_sclk >= 0 && cyc - last_sclk != 16) sclk_bad++;
      last_sclk = cyc; sclk_rises++;
    end
    if (LRCLK && !prev_lrclk) begin
      if (last_lrclk >= 0 && cyc - last_lrclk != 1024) lrclk_bad++;
      last_lrclk = cyc; lrclk_rises++;
    end
    if (valid) begin
      valid_cnt++;
      if (prev_valid) valid_wide++;
      if (last_valid >= 0 && cyc - last_valid != 1024) valid_gap_bad++;
      last_valid = cyc;
      v_lft.push_back(lft_in);
      v_rht.push_back(rht_in);
    end
    prev_mclk = MCLK; prev_sclk = SCLK; prev_lrclk = LRCLK; prev_valid = valid;
    if (m_cnt[3:0] == 4'h8) begin
      s = int'(m_cnt[8:4]);
      if (s >= 1 && s <= 16) dec_sh = {dec_sh[14:0], SDin};
      else if (s >= 17 && SDin) tail_err++;
      if (s == 31) begin
        if (m_cnt[9]) dec_r.push_back(dec_sh);
        else          dec_l.push_back(dec_sh);
      end
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      waitCycle();
      cyc++;
      monitorOutputs();
      if (swap_pending && m_cnt == 10'h200) begin
        lft_out      = new_l;
        rht_out      = new_r;
        swap_pending = 1'b0;
      end
    end
  endtask

  initial begin
    int n, first_rstn, first_valid;
    logic [15:0] got_l, got_r;
    lft_out = 16'hA5A5; rht_out = 16'h5A5A;
    cod_lft = 16'h8001; cod_rht = 16'h7FFE;
    swap_pending = 1'b0; new_l = '0; new_r = '0; cyc = 0;

    repeat (20) waitCycle();
    checkOutput("rst_MCLK",   MCLK,   0);
    checkOutput("rst_SCLK",   SCLK,   0);
    checkOutput("rst_LRCLK",  LRCLK,  0);
    checkOutput("rst_SDin",   SDin,   0);
    checkOutput("rst_RSTn",   RSTn,   0);
    checkOutput("rst_valid",  valid,  0);
    checkOutput("rst_lft_in", lft_in, 0);
    checkOutput("rst_rht_in", rht_in, 0);

    rst = 1'b0;
    n = 0;
    for (int k = 1; k <= 3000; k++) begin
      waitCycle();
      if (RSTn) begin n = k; break; end
    end
    checkOutput("rstn_delay", n, 1024);

    $display("[TB] two frames after RSTn: clocks, RX 8001/7FFE, TX A5A5/5A5A");
    clearMonitor();
    applyStimulus(2048);
    checkOutput("mclk_period",  mclk_bad,    0);
    checkOutput("sclk_period",  sclk_bad,    0);
    checkOutput("lrclk_period", lrclk_bad,   0);
    checkOutput("mclk_rises",   mclk_rises,  512);
    checkOutput("sclk_rises",   sclk_rises,  128);
    checkOutput("lrclk_rises",  lrclk_rises, 2);
    checkOutput("valid_count",  valid_cnt,   2);
    checkOutput("valid_width",  valid_wide,  0);
    checkOutput("valid_gap",    valid_gap_bad, 0);
    checkOutput("rx_lft0", (v_lft.size() > 0) ? v_lft[0] : 16'hDEAD, 16'h8001);
    checkOutput("rx_rht0", (v_rht.size() > 0) ? v_rht[0] : 16'hDEAD, 16'h7FFE);
    checkOutput("rx_lft1", (v_lft.size() > 1) ? v_lft[1] : 16'hDEAD, 16'h8001);
    checkOutput("rx_rht1", (v_rht.size() > 1) ? v_rht[1] : 16'hDEAD, 16'h7FFE);
    checkOutput("tx_lft0", (dec_l.size() > 0) ? dec_l[0] : 16'hDEAD, 16'hA5A5);
    checkOutput("tx_rht0", (dec_r.size() > 0) ? dec_r[0] : 16'hDEAD, 16'h5A5A);
    checkOutput("tx_lft1", (dec_l.size() > 1) ? dec_l[1] : 16'hDEAD, 16'hA5A5);
    checkOutput("tx_rht1", (dec_r.size() > 1) ? dec_r[1] : 16'hDEAD, 16'h5A5A);
    checkOutput("tx_tail_zero", tail_err, 0);

    $display("[TB] mid-frame core update at cnt 200, new codec pair 1357/ECA8");
    cod_lft = 16'h1357; cod_rht = 16'hECA8;
    new_l = 16'h1234; new_r = 16'hFEDC; swap_pending = 1'b1;
    clearMonitor();
    applyStimulus(2048);
    checkOutput("swap_tx_lft_old", (dec_l.size() > 0) ? dec_l[0] : 16'hDEAD, 16'hA5A5);
    checkOutput("swap_tx_rht_old", (dec_r.size() > 0) ? dec_r[0] : 16'hDEAD, 16'h5A5A);
    checkOutput("swap_tx_lft_new", (dec_l.size() > 1) ? dec_l[1] : 16'hDEAD, 16'h1234);
    checkOutput("swap_tx_rht_new", (dec_r.size() > 1) ? dec_r[1] : 16'hDEAD, 16'hFEDC);
    checkOutput("swap_tail_zero", tail_err, 0);
    checkOutput("rx2_lft", (v_lft.size() > 0) ? v_lft[0] : 16'hDEAD, 16'h1357);
    checkOutput("rx2_rht", (v_rht.size() > 0) ? v_rht[0] : 16'hDEAD, 16'hECA8);

    $display("[TB] reset asserted at cnt 250 for 3 clk");
    applyStimulus(10'h250);
    checkOutput("pre_rst_cnt", m_cnt, 10'h250);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_RSTn",   RSTn,   0);
    checkOutput("mid_rst_LRCLK",  LRCLK,  0);
    checkOutput("mid_rst_SDin",   SDin,   0);
    checkOutput("mid_rst_valid",  valid,  0);
    checkOutput("mid_rst_lft_in", lft_in, 0);
    checkOutput("mid_rst_rht_in", rht_in, 0);
    repeat (3) waitCycle();
    rst = 1'b0;
    first_rstn = -1; first_valid = -1; got_l = '0; got_r = '0;
    for (int k = 1; k <= 4000; k++) begin
      waitCycle();
      if (RSTn && first_rstn < 0) first_rstn = k;
      if (valid) begin
        first_valid = k; got_l = lft_in; got_r = rht_in;
        break;
      end
    end
    checkOutput("re_rstn_delay",  first_rstn,  1024);
    checkOutput("re_valid_delay", first_valid, 1920);
    checkOutput("re_rx_lft", got_l, 16'h1357);
    checkOutput("re_rx_rht", got_r, 16'hECA8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
